// File: rtl/phy_rx_deframer.sv
// phy_rx_deframer
//   Receive-side deframer between the PHY and the switch. Registers each
//   50-bit PHY word, checks the sync header and CRC-8, acquires and tracks
//   frame lock, checks sequence numbers, and buffers good flits in a FIFO.
//
// Ports
//   clk             : clock
//   n_rst           : asynchronous active-low reset
//   encoded_flit    : {sync[1:0], seq[7:0], flit[31:0], crc[7:0]} from PHY
//   phy_data_ready  : encoded_flit valid this cycle
//   phy_buffer_full : PHY must hold off while high
//   flit            : FIFO head (0 when empty)
//   sw_data_ready   : FIFO non-empty
//   sw_buffer_full  : switch cannot accept this cycle
//   locked          : frame alignment acquired
//   crc_err_cnt     : saturating CRC failures seen while locked
//   seq_err_cnt     : saturating sequence mismatches
module phy_rx_deframer #(
    parameter int DEPTH        = 4,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [49:0] encoded_flit,
    input  logic        phy_data_ready,
    output logic        phy_buffer_full,
    output logic [31:0] flit,
    output logic        sw_data_ready,
    input  logic        sw_buffer_full,
    output logic        locked,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] seq_err_cnt
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    typedef enum logic {HUNT, LOCKED} state_e;

    // CRC-8, poly 0x07, init 0, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [39:0] d);
        logic [7:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ (((c[7] ^ d[i]) != 1'b0) ? 8'h07 : 8'h00);
        return c;
    endfunction

    // ---------------- input register ----------------
    logic        in_valid_q;
    logic [49:0] in_word_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_valid_q <= 1'b0;
            in_word_q  <= '0;
        end else begin
            in_valid_q <= phy_data_ready;
            in_word_q  <= encoded_flit;
        end
    end

    logic       hdr_ok, crc_ok;
    logic [7:0] seq;

    assign hdr_ok = (in_word_q[49:48] == 2'b10);
    assign crc_ok = (crc8(in_word_q[47:8]) == in_word_q[7:0]);
    assign seq    = in_word_q[47:40];

    // ---------------- lock FSM ----------------
    state_e      state_q, state_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [3:0]  bad_cnt_q, bad_cnt_d;
    logic [7:0]  exp_seq_q, exp_seq_d;
    logic        push, crc_inc, seq_inc;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        exp_seq_d  = exp_seq_q;
        push       = 1'b0;
        crc_inc    = 1'b0;
        seq_inc    = 1'b0;
        if (in_valid_q) begin
            case (state_q)
                HUNT: begin
                    if (hdr_ok && crc_ok) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                        if (lock_cnt_q + 4'd1 == LOCK_N) begin
                            state_d   = LOCKED;
                            exp_seq_d = seq + 8'd1;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (!hdr_ok) begin
                        bad_cnt_d = bad_cnt_q + 4'd1;
                        if (bad_cnt_q + 4'd1 == UNLOCK_N) begin
                            state_d    = HUNT;
                            lock_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end
                    end else if (!crc_ok) begin
                        // Bad payload keeps alignment; exp_seq stays put so
                        // a retransmission of the same seq is accepted.
                        bad_cnt_d = '0;
                        crc_inc   = 1'b1;
                    end else begin
                        bad_cnt_d = '0;
                        push      = 1'b1;
                        seq_inc   = (seq != exp_seq_q);
                        exp_seq_d = seq + 8'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // ---------------- error counters ----------------
    logic [15:0] crc_err_q, crc_err_d, seq_err_q, seq_err_d;

    assign crc_err_d = (crc_inc && crc_err_q != 16'hFFFF) ? crc_err_q + 16'd1 : crc_err_q;
    assign seq_err_d = (seq_inc && seq_err_q != 16'hFFFF) ? seq_err_q + 16'd1 : seq_err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= HUNT;
            lock_cnt_q <= '0;
            bad_cnt_q  <= '0;
            exp_seq_q  <= '0;
            crc_err_q  <= '0;
            seq_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            exp_seq_q  <= exp_seq_d;
            crc_err_q  <= crc_err_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // ---------------- FIFO ----------------
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          pop;
    logic [AW+1:0] occ;

    assign pop = (count_q != '0) && !sw_buffer_full;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are qualified by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_word_q[39:8];
    end

    // The word in the input register already owns a slot, so it is counted.
    assign occ             = {1'b0, count_q} + {{(AW + 1){1'b0}}, in_valid_q};
    assign phy_buffer_full = (occ >= (AW + 2)'(DEPTH));
    assign sw_data_ready   = (count_q != '0);
    assign flit            = sw_data_ready ? mem_q[rd_ptr_q] : 32'h0;
    assign locked          = (state_q == LOCKED);
    assign crc_err_cnt     = crc_err_q;
    assign seq_err_cnt     = seq_err_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Directed bench for phy_rx_deframer: a per-cycle table of inputs and
// expected outputs, plus hand-written async-reset and relock sequences.
module tb_phy_rx_deframer;

    localparam logic [31:0] B = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [49:0] encoded_flit = '0;
    logic        phy_data_ready = 1'b0;
    logic        phy_buffer_full;
    logic [31:0] flit;
    logic        sw_data_ready;
    logic        sw_buffer_full = 1'b0;
    logic        locked;
    logic [15:0] crc_err_cnt;
    logic [15:0] seq_err_cnt;

    phy_rx_deframer #(.DEPTH(4), .LOCK_COUNT(4), .UNLOCK_COUNT(3)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .encoded_flit   (encoded_flit),
        .phy_data_ready (phy_data_ready),
        .phy_buffer_full(phy_buffer_full),
        .flit           (flit),
        .sw_data_ready  (sw_data_ready),
        .sw_buffer_full (sw_buffer_full),
        .locked         (locked),
        .crc_err_cnt    (crc_err_cnt),
        .seq_err_cnt    (seq_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pdr;
        logic [1:0]  hdr;
        logic [7:0]  seq;
        logic [31:0] fl;
        logic        flip;
        logic        swf;
        logic        el;
        logic        er;
        logic [31:0] ef;
        logic        epbf;
        logic [15:0] ecrc;
        logic [15:0] eseq;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Byte-wise CRC-8 (poly 0x07, init 0).
    function automatic logic [7:0] crc_ref(input logic [39:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 4; b >= 0; b--) begin
            c = c ^ d[b*8 +: 8];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic add(input logic pdr, input logic [1:0] hdr, input logic [7:0] seq,
                       input logic [31:0] fl, input logic flip, input logic swf,
                       input logic el, input logic er, input logic [31:0] ef,
                       input logic epbf, input logic [15:0] ecrc, input logic [15:0] eseq);
        vec_t v;
        v.pdr = pdr; v.hdr = hdr; v.seq = seq; v.fl = fl; v.flip = flip; v.swf = swf;
        v.el = el; v.er = er; v.ef = ef; v.epbf = epbf; v.ecrc = ecrc; v.eseq = eseq;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic pdr, input logic [1:0] hdr, input logic [7:0] seq,
                         input logic [31:0] fl, input logic flip, input logic swf);
        logic [49:0] w;
        w = {hdr, seq, fl, crc_ref({seq, fl})};
        if (flip) w[20] = ~w[20];
        encoded_flit   = w;
        phy_data_ready = pdr;
        sw_buffer_full = swf;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic el, input logic er, input logic [31:0] ef,
                           input logic epbf, input logic [15:0] ecrc, input logic [15:0] eseq);
        chk("locked", idx, {31'b0, locked}, {31'b0, el});
        chk("sw_data_ready", idx, {31'b0, sw_data_ready}, {31'b0, er});
        chk("flit", idx, flit, ef);
        chk("phy_buffer_full", idx, {31'b0, phy_buffer_full}, {31'b0, epbf});
        chk("crc_err_cnt", idx, {16'b0, crc_err_cnt}, {16'b0, ecrc});
        chk("seq_err_cnt", idx, {16'b0, seq_err_cnt}, {16'b0, eseq});
    endtask

    initial begin
        // Lock on four all-zero words; locked appears after the 5th edge.
        for (int i = 0; i < 4; i++) add(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 2'b10, 1, B + 1, 0, 0, 1, 0, 0, 0, 0, 0);
        // Pass-through seq 2..8; each output shows the previous word's flit.
        for (int k = 2; k <= 8; k++)
            add(1, 2'b10, 8'(k), B + 32'(k), 0, 0, 1, 1, B + 32'(k - 1), 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0, 1, 1, B + 8, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Backpressure: switch stalled, FIFO fills to DEPTH.
        add(1, 2'b10, 9,  B + 9,  0, 1, 1, 0, 0,      0, 0, 0);
        add(1, 2'b10, 10, B + 10, 0, 1, 1, 1, B + 9,  0, 0, 0);
        add(1, 2'b10, 11, B + 11, 0, 1, 1, 1, B + 9,  0, 0, 0);
        add(1, 2'b10, 12, B + 12, 0, 1, 1, 1, B + 9,  1, 0, 0);
        add(0, 2'b10, 0,  0,      0, 1, 1, 1, B + 9,  1, 0, 0);
        // Release: drain one per cycle.
        add(0, 2'b10, 0, 0, 0, 0, 1, 1, B + 10, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0, 1, 1, B + 11, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0, 1, 1, B + 12, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0, 1, 0, 0,      0, 0, 0);
        // CRC error on seq 13, then its good retransmission.
        add(1, 2'b10, 13, B + 13, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 2'b10, 13, B + 13, 0, 0, 1, 0, 0, 0, 1, 0);
        add(1, 2'b10, 14, B + 14, 0, 0, 1, 1, B + 13, 0, 1, 0);
        // Sequence skip 14 -> 18, then 19 in order.
        add(1, 2'b10, 18, B + 18, 0, 0, 1, 1, B + 14, 0, 1, 0);
        add(1, 2'b10, 19, B + 19, 0, 0, 1, 1, B + 18, 0, 1, 1);
        add(0, 2'b10, 0,  0,      0, 0, 1, 1, B + 19, 0, 1, 1);
        add(0, 2'b10, 0,  0,      0, 0, 1, 0, 0,      0, 1, 1);
        // Three bad headers drop lock.
        for (int i = 0; i < 3; i++) add(1, 2'b01, 20, B + 20, 0, 0, 1, 0, 0, 0, 1, 1);
        add(1, 2'b10, 20, B + 20, 0, 0, 0, 0, 0, 0, 1, 1);
        // Words in HUNT are never delivered; 4 good words relock.
        for (int k = 21; k <= 23; k++) add(1, 2'b10, 8'(k), B + 32'(k), 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 2'b10, 0,  0,      0, 0, 1, 0, 0,      0, 1, 1);
        add(1, 2'b10, 24, B + 24, 0, 0, 1, 0, 0,      0, 1, 1);
        add(0, 2'b10, 0,  0,      0, 0, 1, 1, B + 24, 0, 1, 1);
        add(0, 2'b10, 0,  0,      0, 0, 1, 0, 0,      0, 1, 1);

        // Reset state.
        repeat (2) @(negedge clk);
        chk_all(-1, 0, 0, 0, 0, 0, 0);
        n_rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].pdr, tbl[i].hdr, tbl[i].seq, tbl[i].fl, tbl[i].flip, tbl[i].swf);
            step();
            chk_all(i, tbl[i].el, tbl[i].er, tbl[i].ef, tbl[i].epbf, tbl[i].ecrc, tbl[i].eseq);
        end

        // Async reset mid-stream with a flit in the FIFO.
        drive(1, 2'b10, 25, B + 25, 0, 0);
        step();
        drive(0, 2'b10, 0, 0, 0, 1);
        step();
        chk("pre-reset ready", 100, {31'b0, sw_data_ready}, 32'd1);
        #2 n_rst = 1'b0;
        #1 chk_all(101, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        drive(0, 2'b10, 0, 0, 0, 0);
        step();
        chk_all(102, 0, 0, 0, 0, 0, 0);

        // Relock boundary: not locked until the 4th good word is processed.
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b10, 0, 0, 0, 0);
            step();
            chk("relock early", 110 + i, {31'b0, locked}, 32'd0);
        end
        drive(0, 2'b10, 0, 0, 0, 0);
        step();
        chk("relock", 114, {31'b0, locked}, 32'd1);
        chk("relock ready", 114, {31'b0, sw_data_ready}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phy_rx_deframer.md
# phy_rx_deframer

Receive-side deframer between the PHY and the switch. Accepts 50-bit encoded words from the PHY, acquires and tracks frame alignment, checks CRC-8 and sequence numbers, and buffers good flits in a FIFO. Its PHY side is the `rx_phy` view of the PHY manager interface; its switch side is the `rx_switch` view.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `LOCK_COUNT`, 4: consecutive good words needed to lock, 1–15.
- `UNLOCK_COUNT`, 3: consecutive bad headers that drop lock, 1–15.

Ports:
- `clk` input 1: the block's single clock.
- `n_rst` input 1: reset, asynchronous and active-low.
- `encoded_flit` input 50: PHY word.
  - [49:48] sync header, 2'b10 valid.
  - [47:40] sequence number.
  - [39:8] flit (flit_t, 32 bits).
  - [7:0] CRC-8.
- `phy_data_ready` input 1: `encoded_flit` valid this cycle.
- `phy_buffer_full` output 1: PHY must not assert `phy_data_ready` while high.
- `flit` output 32: FIFO head; 32'h0 when empty.
- `sw_data_ready` output 1: FIFO non-empty.
- `sw_buffer_full` input 1: switch cannot accept.
- `locked` output 1: state is LOCKED.
- `crc_err_cnt` output 16: saturating count of CRC failures while LOCKED.
- `seq_err_cnt` output 16: saturating count of sequence mismatches.

## Operation
- **Capture:** a word is accepted when `phy_data_ready` is high. It goes into a single input register (`in_valid`, `in_word`). The input register is loaded every cycle, and `in_valid` is cleared when no word is presented.
- **Check:** done on the input register.
  - hdr_ok = [49:48] is 2'b10.
  - crc_ok = CRC-8 over [47:8] equals [7:0].
  - CRC polynomial 0x07, init 0x00, MSB first, no reflection, no final XOR.
- **State machine:** two states.
  - HUNT (reset state):
    - A word with hdr_ok and crc_ok increments lock_cnt; any other word clears lock_cnt.
    - When lock_cnt reaches LOCK_COUNT: go to LOCKED, set exp_seq = word seq + 1 (mod 256), clear bad_cnt.
    - Words received in HUNT are never pushed to the FIFO.
  - LOCKED:
    - !hdr_ok: drop the word and increment bad_cnt. When bad_cnt reaches UNLOCK_COUNT, go to HUNT and clear lock_cnt.
    - hdr_ok and !crc_ok: drop the word, clear bad_cnt, increment crc_err_cnt. exp_seq is unchanged.
    - hdr_ok and crc_ok: clear bad_cnt and push the flit. If seq ≠ exp_seq, increment seq_err_cnt; the flit is still pushed. Then set exp_seq = seq + 1.
- **FIFO:**
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Pop when `sw_data_ready && !sw_buffer_full`.
  - Push and pop in the same cycle leave count unchanged. This includes a push while full if a pop occurs in the same cycle.
- **Flow control:** `phy_buffer_full` = (count + in_valid ≥ DEPTH), combinational. A word accepted while this is low always has a FIFO slot, so no overflow is possible.
- **Error counters:** saturate at 16'hFFFF and are cleared only by reset.

## Timing
- **Reset:**
  - State HUNT; lock_cnt, bad_cnt and exp_seq are 0; FIFO is empty; `in_valid` is 0.
  - All outputs are 0: `flit`, `sw_data_ready`, `phy_buffer_full`, `locked`, `crc_err_cnt`, `seq_err_cnt`.
  - Reset asserted mid-operation discards FIFO contents and lock immediately.
- **Latency:** a word sampled at edge E0 is in the input register after E0 and written to the FIFO at E1. `sw_data_ready` and `flit` reflect it after E1. Minimum latency is 2 cycles.
- **Lock timing:** `locked` rises after the edge that processes the LOCK_COUNT-th good word. It falls after the edge that processes the UNLOCK_COUNT-th consecutive bad header.
- **Throughput:** one word per cycle sustained while the switch pops every cycle.
- **Combinational outputs:** `flit` and `sw_data_ready` derive from FIFO state only. `phy_buffer_full` derives from count and `in_valid`.

## Test plan
- **Reset and lock:** reset, then 4 all-zero words (header 2'b10, seq 0, flit 0, CRC 8'h00).
  - `locked` rises 1 cycle after the 4th word is captured.
  - `sw_data_ready` stays 0.
  - exp_seq is 1.
- **Pass-through:** after lock, send seq 1..8 with bench-model CRC and flit = 32'hA5A5_0000+seq, with the switch always ready.
  - Each flit appears 2 cycles after its input, in order.
  - Both error counters stay 0.
- **Backpressure:** DEPTH=4, hold `sw_buffer_full`=1 and stream words.
  - `phy_buffer_full` goes high once count+`in_valid` reaches 4.
  - Release: 4 flits drain one per cycle, in order, across pointer wrap.
- **CRC error:** flip bit 20 of a seq-3 word.
  - The word is dropped and crc_err_cnt = 1.
  - The next word (seq 3) is delivered with no seq error.
- **Sequence skip:** send seq 5 then seq 9.
  - seq_err_cnt = 1 and both flits are delivered.
  - A following seq 10 causes no further error.
- **Unlock:** send 3 words with header 2'b01.
  - `locked` falls after the 3rd.
  - Subsequent good words are not delivered until 4 consecutive good words relock.
  - Asserting `n_rst` mid-stream clears everything asynchronously.
